// File: rtl/vga_timing_gen.sv
// Programmable VGA raster timing generator: counters, syncs, active qualifiers, line/frame strobes.
// Optional frame counter enabled by defining VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned H_FP     = 40,
  parameter int unsigned H_SYNC   = 128,
  parameter int unsigned H_BP     = 88,
  parameter int unsigned V_ACTIVE = 600,
  parameter int unsigned V_FP     = 1,
  parameter int unsigned V_SYNC   = 4,
  parameter int unsigned V_BP     = 23,
  parameter bit          HS_POL   = 1'b1,
  parameter bit          VS_POL   = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic        pix_ce,
  output logic [10:0] pixel_x,
  output logic [9:0]  pixel_y,
  output logic        h_active,
  output logic        v_active,
  output logic        hsync,
  output logic        vsync,
  output logic        line_start,
  output logic        frame_start,
  output logic [7:0]  frame_cnt
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 2048) begin : g_h_total_chk
    $error("vga_timing_gen: H_TOTAL %0d exceeds 2048", H_TOTAL);
  end
  if (V_TOTAL > 1024) begin : g_v_total_chk
    $error("vga_timing_gen: V_TOTAL %0d exceeds 1024", V_TOTAL);
  end

  // Decode bounds are one bit wider than the counters so a range ending at 2048/1024 still fits.
  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT_END  = 12'(H_ACTIVE);
  localparam logic [11:0] HS_START   = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END     = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_ACT_END  = 11'(V_ACTIVE);
  localparam logic [10:0] VS_START   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END     = 11'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic {S_IDLE, S_RUN} state_t;
  state_t state;

  logic        x_wrap;
  logic        y_wrap;
  logic [10:0] ld_x;
  logic [9:0]  ld_y;

  // Position to be loaded on the next advancing edge; entry from IDLE always starts at (0,0).
  always_comb begin
    x_wrap = (pixel_x == H_LAST);
    y_wrap = (pixel_y == V_LAST);
    ld_x   = '0;
    ld_y   = '0;
    if (state == S_RUN) begin
      ld_x = x_wrap ? '0 : pixel_x + 11'd1;
      if (x_wrap)
        ld_y = y_wrap ? '0 : pixel_y + 10'd1;
      else
        ld_y = pixel_y;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      pixel_x     <= '0;
      pixel_y     <= '0;
      h_active    <= 1'b0;
      v_active    <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (!en) begin
      state       <= S_IDLE;
      pixel_x     <= '0;
      pixel_y     <= '0;
      h_active    <= 1'b0;
      v_active    <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (!pix_ce) begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      state       <= S_RUN;
      pixel_x     <= ld_x;
      pixel_y     <= ld_y;
      h_active    <= ({1'b0, ld_x} < H_ACT_END);
      v_active    <= ({1'b0, ld_y} < V_ACT_END);
      hsync       <= (({1'b0, ld_x} >= HS_START) && ({1'b0, ld_x} < HS_END)) ? HS_POL : ~HS_POL;
      vsync       <= (({1'b0, ld_y} >= VS_START) && ({1'b0, ld_y} < VS_END)) ? VS_POL : ~VS_POL;
      line_start  <= (ld_x == '0);
      frame_start <= (ld_x == '0) && (ld_y == '0);
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      frame_cnt <= '0;
    else if (!en)
      frame_cnt <= '0;
    else if (pix_ce && (state == S_RUN) && x_wrap && y_wrap)
      frame_cnt <= frame_cnt + 8'd1;
  end
`else
  assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: small-geometry DUT against a linear-position frame model,
// plus a default-geometry DUT checking the hsync/h_active edges on the first line.
module tb_vga_timing_gen;

  localparam int HA = 8, HF = 2, HSY = 2, HB = 2;
  localparam int VA = 4, VF = 1, VSY = 1, VB = 1;
  localparam int HT = HA + HF + HSY + HB;
  localparam int VT = VA + VF + VSY + VB;
  localparam int FR = HT * VT;
`ifdef VGA_TIMING_FRAME_CNT_EN
  localparam bit FC_EN = 1'b1;
`else
  localparam bit FC_EN = 1'b0;
`endif

  typedef struct packed {
    logic [10:0] x;
    logic [9:0]  y;
    logic        ha, va, hs, vs, ls, fs;
    logic [7:0]  fc;
  } obs_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic en = 1'b0;
  logic pix_ce = 1'b0;
  logic [10:0] pixel_x;
  logic [9:0]  pixel_y;
  logic h_active, v_active, hsync, vsync, line_start, frame_start;
  logic [7:0] frame_cnt;

  logic reset2_n = 1'b0;
  logic en2 = 1'b0;
  logic pce2 = 1'b0;
  logic [10:0] pixel_x2;
  logic [9:0]  pixel_y2;
  logic h_active2, v_active2, hsync2, vsync2, line_start2, frame_start2;
  logic [7:0] frame_cnt2;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .pix_ce(pix_ce),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .h_active(h_active), .v_active(v_active),
    .hsync(hsync), .vsync(vsync), .line_start(line_start), .frame_start(frame_start),
    .frame_cnt(frame_cnt)
  );

  vga_timing_gen dut2 (
    .clk(clk), .reset_n(reset2_n), .en(en2), .pix_ce(pce2),
    .pixel_x(pixel_x2), .pixel_y(pixel_y2), .h_active(h_active2), .v_active(v_active2),
    .hsync(hsync2), .vsync(vsync2), .line_start(line_start2), .frame_start(frame_start2),
    .frame_cnt(frame_cnt2)
  );

  int n_chk = 0;
  int n_pass = 0;
  obs_t exp_q[$];
  bit done2 = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
  endtask

  // Reference model: the raster is a single position within the frame, x/y derived arithmetically.
  bit m_run = 1'b0;
  int m_pos = 0;
  int m_fc  = 0;
  bit m_ls  = 1'b0;
  bit m_fs  = 1'b0;

  function automatic obs_t model_obs();
    obs_t o;
    int x, y;
    o = '0;
    if (m_run) begin
      x = m_pos % HT;
      y = m_pos / HT;
      o.x  = 11'(x);
      o.y  = 10'(y);
      o.ha = (x < HA);
      o.va = (y < VA);
      o.hs = (x >= HA + HF) && (x < HA + HF + HSY);
      o.vs = (y >= VA + VF) && (y < VA + VF + VSY);
      o.ls = m_ls;
      o.fs = m_fs;
      o.fc = FC_EN ? 8'(m_fc % 256) : 8'h00;
    end
    return o;
  endfunction

  function automatic void model_step(input bit e, input bit p);
    m_ls = 1'b0;
    m_fs = 1'b0;
    if (!e) begin
      m_run = 1'b0;
      m_pos = 0;
      m_fc  = 0;
    end else if (p) begin
      if (!m_run) begin
        m_run = 1'b1;
        m_pos = 0;
      end else begin
        m_pos = (m_pos + 1) % FR;
        if (m_pos == 0) m_fc++;
      end
      m_ls = (m_pos % HT == 0);
      m_fs = (m_pos == 0);
    end
  endfunction

  task automatic drive(input bit e, input bit p);
    @(negedge clk);
    en = e;
    pix_ce = p;
    model_step(e, p);
    exp_q.push_back(model_obs());
  endtask

  // Monitor: the DUT presents a new output set after every edge.
  initial begin
    obs_t act, exp;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        act = '{x: pixel_x, y: pixel_y, ha: h_active, va: v_active, hs: hsync,
                vs: vsync, ls: line_start, fs: frame_start, fc: frame_cnt};
        chk($sformatf("raster(x=%0d,y=%0d)", exp.x, exp.y), 64'(act), 64'(exp));
      end
    end
  end

  // Default-geometry checks: first hsync rise and first h_active fall on line 0.
  initial begin
    bit prev_hs, prev_ha, seen_hs, seen_ha;
    prev_hs = 1'b0; prev_ha = 1'b0; seen_hs = 1'b0; seen_ha = 1'b0;
    repeat (3) @(negedge clk);
    chk("dflt_reset_hsync", 64'(hsync2), 64'(0));
    chk("dflt_reset_vsync", 64'(vsync2), 64'(0));
    reset2_n = 1'b1;
    en2 = 1'b1;
    pce2 = 1'b1;
    for (int c = 0; c < 1200; c++) begin
      @(posedge clk);
      #1;
      if (!seen_hs && hsync2 && !prev_hs) begin
        chk("dflt_hsync_rise_x", 64'(pixel_x2), 64'(840));
        chk("dflt_hsync_rise_y", 64'(pixel_y2), 64'(0));
        seen_hs = 1'b1;
      end
      if (!seen_ha && !h_active2 && prev_ha) begin
        chk("dflt_hactive_fall_x", 64'(pixel_x2), 64'(800));
        seen_ha = 1'b1;
      end
      prev_hs = hsync2;
      prev_ha = h_active2;
    end
    chk("dflt_hsync_rise_seen", 64'(seen_hs), 64'(1));
    chk("dflt_hactive_fall_seen", 64'(seen_ha), 64'(1));
    done2 = 1'b1;
  end

  initial begin
    int guard;
    repeat (3) @(negedge clk);
    chk("reset_x", 64'(pixel_x), 64'(0));
    chk("reset_y", 64'(pixel_y), 64'(0));
    chk("reset_hactive", 64'(h_active), 64'(0));
    chk("reset_vactive", 64'(v_active), 64'(0));
    chk("reset_hsync", 64'(hsync), 64'(0));
    chk("reset_vsync", 64'(vsync), 64'(0));
    chk("reset_strobes", 64'({line_start, frame_start}), 64'(0));
    chk("reset_frame_cnt", 64'(frame_cnt), 64'(0));
    reset_n = 1'b1;

    repeat (3 * FR + 5) drive(1'b1, 1'b1);
    for (int i = 0; i < 2 * FR + 10; i++) drive(1'b1, (i % 2) == 0);

    // Abort at (5,2), then restart.
    guard = 0;
    while (!(m_run && m_pos == 2 * HT + 5) && guard < 2 * FR) begin
      drive(1'b1, 1'b1);
      guard++;
    end
    chk("abort_reached", 64'(m_pos), 64'(2 * HT + 5));
    drive(1'b0, 1'b1);
    drive(1'b1, 1'b1);
    repeat (30) drive(1'b1, 1'b1);

    for (int i = 0; i < 1500; i++)
      drive($urandom_range(0, 39) != 0, $urandom_range(0, 3) != 0);

    // Asynchronous reset mid-run, away from any clock edge.
    repeat (20) drive(1'b1, 1'b1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("areset_x", 64'(pixel_x), 64'(0));
    chk("areset_y", 64'(pixel_y), 64'(0));
    chk("areset_hactive", 64'(h_active), 64'(0));
    chk("areset_hsync", 64'(hsync), 64'(0));
    chk("areset_strobes", 64'({line_start, frame_start}), 64'(0));
    chk("areset_frame_cnt", 64'(frame_cnt), 64'(0));
    m_run = 1'b0; m_pos = 0; m_fc = 0;
    en = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (FR + 20) drive(1'b1, 1'b1);

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    guard = 0;
    while (!done2 && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    chk("dflt_done", 64'(done2), 64'(1));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
